// File: rtl/regfile_op_sequencer.sv
// Instruction sequencer for an 8x8 two-read/one-write register file.
// Takes 16-bit three-address instructions over valid/ready, reads both operands,
// runs a small ALU, then writes back with address/data set up one cycle before
// a single-cycle write_enable strobe. All outputs are registered.
module regfile_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_instr_valid,
  output logic              o_instr_ready,
  input  logic [15:0]       i_instr,
  output logic [ADDR_W-1:0] o_read_address_1,
  output logic [ADDR_W-1:0] o_read_address_2,
  output logic              o_read_enable,
  input  logic [DATA_W-1:0] i_read_data_1,
  input  logic [DATA_W-1:0] i_read_data_2,
  output logic [ADDR_W-1:0] o_write_address,
  output logic [DATA_W-1:0] o_write_data,
  output logic              o_write_enable,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_READ     = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_WB_SETUP = 3'd3;
  localparam logic [2:0] S_WB_PULSE = 3'd4;
  localparam logic [2:0] S_WB_HOLD  = 3'd5;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  logic [2:0]        r_state;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_res_carry;

  // Extra top bit carries ADD carry-out, SUB borrow and the last SHL bit shifted out.
  logic [DATA_W:0]   w_wide;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_carry;

  // ALU on the captured operands; evaluated while in EXEC.
  always_comb begin
    // NOTE: default assignment first so no op path leaves w_wide unassigned (no latch).
    w_wide = '0;
    case (r_op)
      OP_ADD:  w_wide = {1'b0, r_a} + {1'b0, r_b};
      OP_SUB:  w_wide = {1'b0, r_a} - {1'b0, r_b};
      OP_AND:  w_wide = {1'b0, r_a & r_b};
      OP_OR:   w_wide = {1'b0, r_a | r_b};
      OP_XOR:  w_wide = {1'b0, r_a ^ r_b};
      OP_SHL:  w_wide = {1'b0, r_a} << r_b[2:0];
      OP_LDI:  w_wide = {1'b0, r_imm};
      default: w_wide = '0;
    endcase
  end

  assign w_alu_res   = w_wide[DATA_W-1:0];
  assign w_alu_carry = w_wide[DATA_W];

  // Sequencer FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset along with the FSM so every output is
    // defined from reset; an async reset also drops write_enable mid-strobe.
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_op             <= OP_NOP;
      r_rd             <= '0;
      r_imm            <= '0;
      r_a              <= '0;
      r_b              <= '0;
      r_res_carry      <= 1'b0;
      o_instr_ready    <= 1'b1;
      o_read_address_1 <= '0;
      o_read_address_2 <= '0;
      o_read_enable    <= 1'b0;
      o_write_address  <= '0;
      o_write_data     <= '0;
      o_write_enable   <= 1'b0;
      o_done           <= 1'b0;
      o_result         <= '0;
      o_carry          <= 1'b0;
      o_zero           <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere so each register samples pre-edge values.
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_instr_valid) begin
            r_op          <= i_instr[15:13];
            r_rd          <= i_instr[10 +: ADDR_W];
            r_imm         <= DATA_W'(i_instr[7:0]);
            o_instr_ready <= 1'b0;
            if (i_instr[15:13] == OP_LDI) begin
              r_state <= S_EXEC;
            end else begin
              o_read_address_1 <= i_instr[7 +: ADDR_W];
              o_read_address_2 <= i_instr[4 +: ADDR_W];
              o_read_enable    <= 1'b1;
              r_state          <= S_READ;
            end
          end
        end
        S_READ: begin
          // Register file read is combinational, so data is valid by this edge.
          r_a           <= i_read_data_1;
          r_b           <= i_read_data_2;
          o_read_enable <= 1'b0;
          r_state       <= S_EXEC;
        end
        S_EXEC: begin
          if (r_op == OP_NOP) begin
            o_done        <= 1'b1;
            o_instr_ready <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            // Only place write address/data change: stable across the strobe edge.
            o_write_address <= r_rd;
            o_write_data    <= w_alu_res;
            r_res_carry     <= w_alu_carry;
            r_state         <= S_WB_SETUP;
          end
        end
        S_WB_SETUP: begin
          o_write_enable <= 1'b1;
          r_state        <= S_WB_PULSE;
        end
        S_WB_PULSE: begin
          o_write_enable <= 1'b0;
          o_done         <= 1'b1;
          o_result       <= o_write_data;
          o_carry        <= r_res_carry;
          o_zero         <= (o_write_data == '0);
          r_state        <= S_WB_HOLD;
        end
        S_WB_HOLD: begin
          o_instr_ready <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: begin
          o_instr_ready  <= 1'b1;
          o_read_enable  <= 1'b0;
          o_write_enable <= 1'b0;
          r_state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Testbench for regfile_op_sequencer: a behavioural register file on the DUT ports,
// plus an architectural model (register array and flags) computed with plain arithmetic.
module tb_regfile_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0;
  logic [2:0]  read_address_1, read_address_2, write_address;
  logic        read_enable, write_enable, done, carry, zero;
  logic [7:0]  read_data_1, read_data_2, write_data, result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_op_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_instr_valid(instr_valid), .o_instr_ready(instr_ready), .i_instr(instr),
    .o_read_address_1(read_address_1), .o_read_address_2(read_address_2),
    .o_read_enable(read_enable),
    .i_read_data_1(read_data_1), .i_read_data_2(read_data_2),
    .o_write_address(write_address), .o_write_data(write_data),
    .o_write_enable(write_enable), .o_done(done),
    .o_result(result), .o_carry(carry), .o_zero(zero)
  );

  // Register file attached to the DUT: combinational reads, write on posedge write_enable.
  logic [7:0] rf [8] = '{default: 8'h00};
  int we_rises = 0;
  assign read_data_1 = rf[read_address_1];
  assign read_data_2 = rf[read_address_2];
  always @(posedge write_enable) begin
    rf[write_address] <= write_data;
    we_rises <= we_rises + 1;
  end

  // Architectural model state.
  int m [8] = '{default: 0};
  int m_res = 0, m_carry = 0, m_zero = 0;

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return {3'(op), 3'(rd), 3'(rs1), 3'(rs2), 4'h0};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {3'b110, 3'(rd), 2'b00, 8'(imm)};
  endfunction

  function automatic void model_op(input logic [15:0] ins, output int res, output int cy, output bit wr);
    int a, b, s;
    a = m[ins[9:7]];
    b = m[ins[6:4]];
    s = b % 8;
    wr = 1'b1; cy = 0; res = 0;
    case (int'(ins[15:13]))
      0: begin res = a + b; cy = (res > 255) ? 1 : 0; res = res % 256; end
      1: begin cy = (a < b) ? 1 : 0; res = (a - b + 256) % 256; end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a * (1 << s)) % 256; cy = (s == 0) ? 0 : (a / (1 << (8 - s))) % 2; end
      6: res = int'(ins[7:0]);
      default: begin wr = 1'b0; res = m_res; cy = m_carry; end
    endcase
  endfunction

  task automatic model_commit(input logic [15:0] ins);
    int res, cy;
    bit wr;
    model_op(ins, res, cy, wr);
    if (wr) begin
      m[ins[12:10]] = res;
      m_res = res; m_carry = cy; m_zero = (res == 0) ? 1 : 0;
    end
  endtask

  // Observations of one instruction; k counts edges after the accept edge, and a
  // sample at k is taken in the cycle that ends at edge k.
  int obs_we_cnt, obs_we_cyc, obs_done_cnt, obs_done_cyc;
  logic [2:0] obs_wa;
  logic [7:0] obs_wd;
  bit obs_stable;

  task automatic run_instr(input logic [15:0] ins);
    logic [2:0] pa;
    logic [7:0] pd;
    int n;
    n = 0; pa = '0; pd = '0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL ready_timeout: instr_ready=%b after %0d cycles, want 1", instr_ready, n);
    end
    instr = ins; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; instr = 16'($urandom);
    obs_we_cnt = 0; obs_we_cyc = 0; obs_done_cnt = 0; obs_done_cyc = 0;
    obs_wa = '0; obs_wd = '0; obs_stable = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (write_enable === 1'b1) begin
        if (obs_we_cnt == 0) begin
          obs_we_cyc = k; obs_wa = write_address; obs_wd = write_data;
          obs_stable = (k > 1) && (pa === write_address) && (pd === write_data);
        end
        obs_we_cnt++;
      end
      if (done === 1'b1) begin
        if (obs_done_cnt == 0) obs_done_cyc = k;
        obs_done_cnt++;
      end
      pa = write_address; pd = write_data;
      if (k < 8) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({instr_ready, read_enable, write_enable, done} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl: ready/re/we/done=%b, want 1000", {instr_ready, read_enable, write_enable, done});
    end
    checks++;
    if ({read_address_1, read_address_2, write_address, write_data, result, carry, zero} !== 27'd0) begin
      errors++; $display("FAIL reset_data: ra1=%h ra2=%h wa=%h wd=%h res=%h c=%b z=%b, want all 0",
        read_address_1, read_address_2, write_address, write_data, result, carry, zero);
    end
  endtask

  task automatic test_ldi_add();
    model_commit(ldi(1, 'h7F)); run_instr(ldi(1, 'h7F));
    checks++;
    if (obs_we_cyc != 3 || obs_done_cyc != 4 || obs_we_cnt != 1 || obs_done_cnt != 1) begin
      errors++; $display("FAIL ldi_timing: we@%0d done@%0d we_cnt=%0d done_cnt=%0d, want 3 4 1 1",
        obs_we_cyc, obs_done_cyc, obs_we_cnt, obs_done_cnt);
    end
    model_commit(ldi(2, 'h81)); run_instr(ldi(2, 'h81));
    model_commit(enc(0, 3, 1, 2)); run_instr(enc(0, 3, 1, 2));
    checks++;
    if (obs_we_cyc != 4 || obs_done_cyc != 5 || obs_we_cnt != 1 || obs_done_cnt != 1) begin
      errors++; $display("FAIL add_timing: we@%0d done@%0d we_cnt=%0d done_cnt=%0d, want 4 5 1 1",
        obs_we_cyc, obs_done_cyc, obs_we_cnt, obs_done_cnt);
    end
    checks++;
    if ({result, carry, zero} !== {8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL add_flags: res=%h c=%b z=%b, want 00 1 1", result, carry, zero);
    end
    checks++;
    if ({rf[1], rf[2], rf[3]} !== {8'h7F, 8'h81, 8'h00}) begin
      errors++; $display("FAIL add_regs: r1=%h r2=%h r3=%h, want 7f 81 00", rf[1], rf[2], rf[3]);
    end
  endtask

  task automatic test_sub();
    model_commit(enc(1, 4, 2, 1)); run_instr(enc(1, 4, 2, 1));
    checks++;
    if ({rf[4], result, carry, zero} !== {8'h02, 8'h02, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_nb: r4=%h res=%h c=%b z=%b, want 02 02 0 0", rf[4], result, carry, zero);
    end
    model_commit(enc(1, 5, 1, 2)); run_instr(enc(1, 5, 1, 2));
    checks++;
    if ({rf[5], result, carry, zero} !== {8'hFE, 8'hFE, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_borrow: r5=%h res=%h c=%b z=%b, want fe fe 1 0", rf[5], result, carry, zero);
    end
  endtask

  task automatic test_shl();
    model_commit(ldi(1, 'h81)); run_instr(ldi(1, 'h81));
    model_commit(ldi(2, 'h01)); run_instr(ldi(2, 'h01));
    model_commit(enc(5, 6, 1, 2)); run_instr(enc(5, 6, 1, 2));
    checks++;
    if ({rf[6], result, carry} !== {8'h02, 8'h02, 1'b1}) begin
      errors++; $display("FAIL shl_1: r6=%h res=%h c=%b, want 02 02 1", rf[6], result, carry);
    end
    model_commit(ldi(2, 'h08)); run_instr(ldi(2, 'h08));
    model_commit(enc(5, 7, 1, 2)); run_instr(enc(5, 7, 1, 2));
    checks++;
    if ({rf[7], result, carry} !== {8'h81, 8'h81, 1'b0}) begin
      errors++; $display("FAIL shl_0: r7=%h res=%h c=%b, want 81 81 0", rf[7], result, carry);
    end
  endtask

  task automatic test_alias_setup();
    model_commit(ldi(1, 'h05)); run_instr(ldi(1, 'h05));
    model_commit(enc(0, 1, 1, 1)); run_instr(enc(0, 1, 1, 1));
    checks++;
    if (rf[1] !== 8'h0A || result !== 8'h0A) begin
      errors++; $display("FAIL alias_add: r1=%h res=%h, want 0a 0a", rf[1], result);
    end
    checks++;
    if (!obs_stable || obs_wa !== 3'd1 || obs_wd !== 8'h0A) begin
      errors++; $display("FAIL wb_setup: stable=%b wa=%h wd=%h, want 1 1 0a", obs_stable, obs_wa, obs_wd);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    int op;
    for (int r = 0; r < 8; r++) begin
      ins = ldi(r, $urandom_range(0, 255)); model_commit(ins); run_instr(ins);
    end
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 7);
      ins = (op == 6) ? ldi($urandom_range(0, 7), $urandom_range(0, 255))
                      : enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      model_commit(ins); run_instr(ins);
      checks++;
      if ({result, carry, zero} !== {8'(m_res), 1'(m_carry), 1'(m_zero)} ||
          rf[ins[12:10]] !== 8'(m[ins[12:10]]) || obs_we_cnt != ((op == 7) ? 0 : 1) || obs_done_cnt != 1) begin
        errors++; $display("FAIL rand_%0d: ins=%h res=%h c=%b z=%b rd=%h we=%0d done=%0d, want %h %0d %0d %h %0d 1",
          i, ins, result, carry, zero, rf[ins[12:10]], obs_we_cnt, obs_done_cnt,
          8'(m_res), m_carry, m_zero, 8'(m[ins[12:10]]), (op == 7) ? 0 : 1);
      end
    end
  endtask

  task automatic test_nop();
    int base;
    base = we_rises;
    model_commit(enc(7, 3, 4, 5)); run_instr(enc(7, 3, 4, 5));
    checks++;
    if (obs_done_cnt != 1 || obs_done_cyc != 3 || obs_we_cnt != 0 || we_rises != base) begin
      errors++; $display("FAIL nop_ctrl: done_cnt=%0d done@%0d we_cnt=%0d writes=%0d, want 1 3 0 0",
        obs_done_cnt, obs_done_cyc, obs_we_cnt, we_rises - base);
    end
    checks++;
    if ({result, carry, zero} !== {8'(m_res), 1'(m_carry), 1'(m_zero)}) begin
      errors++; $display("FAIL nop_hold: res=%h c=%b z=%b, want %h %0d %0d", result, carry, zero, 8'(m_res), m_carry, m_zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ins;
    int rp[$];
    int dn, base, n;
    bit ok;
    ins = enc(0, 0, 1, 2);
    dn = 0; n = 0; base = we_rises;
    @(negedge clk);
    while (instr_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    instr = ins; instr_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (instr_ready === 1'b1) rp.push_back(c);
      if (done === 1'b1) dn++;
      instr = (instr_ready === 1'b1) ? ins : 16'($urandom);
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) model_commit(ins);
    ok = (rp.size() == 5);
    for (int i = 1; i < rp.size(); i++) if (rp[i] - rp[i-1] != 6) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_ready: %0d ready pulses, first@%0d, want 5 pulses spaced 6", rp.size(), (rp.size() > 0) ? rp[0] : -1);
    end
    checks++;
    if (dn != 5 || we_rises - base != 5 || result !== 8'(m_res)) begin
      errors++; $display("FAIL b2b_retire: done=%0d writes=%0d res=%h, want 5 5 %h", dn, we_rises - base, result, 8'(m_res));
    end
    ok = 1'b1;
    for (int r = 0; r < 8; r++) if (rf[r] !== 8'(m[r])) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL regfile: r0..r7=%h %h %h %h %h %h %h %h, want %h %h %h %h %h %h %h %h",
        rf[0], rf[1], rf[2], rf[3], rf[4], rf[5], rf[6], rf[7],
        8'(m[0]), 8'(m[1]), 8'(m[2]), 8'(m[3]), 8'(m[4]), 8'(m[5]), 8'(m[6]), 8'(m[7]));
    end
  endtask

  task automatic test_reset_mid();
    int base;
    // Abort in WB_SETUP: the strobe must never rise, r7 keeps its value.
    base = we_rises;
    @(negedge clk);
    instr = enc(0, 7, 1, 2); instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || write_enable !== 1'b0 || write_address !== 3'd0) begin
      errors++; $display("FAIL rst_setup: ready=%b we=%b wa=%h, want 1 0 0", instr_ready, write_enable, write_address);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (we_rises != base || rf[7] !== 8'(m[7]) || result !== 8'h00) begin
      errors++; $display("FAIL rst_nowrite: writes=%0d r7=%h res=%h, want 0 %h 00", we_rises - base, rf[7], 8'(m[7]), result);
    end
    // Abort in WB_PULSE: write_enable must fall asynchronously.
    instr = enc(3, 6, 1, 2); instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (write_enable !== 1'b1) begin
      errors++; $display("FAIL pulse_pre: we=%b, want 1", write_enable);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({write_enable, instr_ready, done} !== 3'b010) begin
      errors++; $display("FAIL rst_pulse: we/ready/done=%b, want 010", {write_enable, instr_ready, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(ldi(0, 'h3C));
    checks++;
    if (result !== 8'h3C || rf[0] !== 8'h3C || obs_we_cyc != 3) begin
      errors++; $display("FAIL rst_recover: res=%h r0=%h we@%0d, want 3c 3c 3", result, rf[0], obs_we_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_ldi_add();
    test_sub();
    test_shl();
    test_alias_setup();
    test_random();
    test_nop();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
